// File: rtl/lr_pkg.sv
// Shared types and constants for the linear-regression SGD training slice.
// Gray-coded sequencer states plus datapath sizing used across the block.
package lr_pkg;

  localparam int DP_BITS      = 4;
  localparam int EPOCH_BITS   = 8;
  localparam int MAX_FEATURES = 6;
  localparam int LR_SHIFT     = 7;
  localparam int Q_WIDTH      = 16;

  // Adjacent states differ in one bit along the per-point loop
  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_FETCH = 3'b001,
    S_WAIT  = 3'b011,
    S_FWD   = 3'b010,
    S_ERR   = 3'b110,
    S_UPD   = 3'b111,
    S_WRT   = 3'b101,
    S_DONE  = 3'b100
  } state_t;

endpackage

// File: rtl/lr_loop_counter.sv
// Data-point address down-counter with reload and epoch up-counter.
// Holds the run configuration latched on load.
module lr_loop_counter #(
  parameter int DP_BITS    = 4,
  parameter int EPOCH_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [DP_BITS-1:0]    n_in,
  input  logic [EPOCH_BITS-1:0] e_in,
  output logic [DP_BITS-1:0]    addr,
  output logic [EPOCH_BITS-1:0] epoch,
  output logic                  last_dp,
  output logic                  last_epoch
);

  logic [DP_BITS-1:0]    n_q, n_d;
  logic [EPOCH_BITS-1:0] e_q, e_d;
  logic [DP_BITS-1:0]    addr_q, addr_d;
  logic [EPOCH_BITS-1:0] epoch_q, epoch_d;

  always_comb begin
    n_d     = n_q;
    e_d     = e_q;
    addr_d  = addr_q;
    epoch_d = epoch_q;
    if (load) begin
      n_d     = n_in;
      e_d     = e_in;
      addr_d  = n_in - 1'b1;
      epoch_d = '0;
    end else if (step) begin
      if (addr_q != '0) begin
        addr_d = addr_q - 1'b1;
      end else begin
        addr_d  = n_q - 1'b1;
        epoch_d = epoch_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      e_q     <= '0;
      addr_q  <= '0;
      epoch_q <= '0;
    end else begin
      n_q     <= n_d;
      e_q     <= e_d;
      addr_q  <= addr_d;
      epoch_q <= epoch_d;
    end
  end

  assign addr       = addr_q;
  assign epoch      = epoch_q;
  assign last_dp    = (addr_q == '0);
  // E >= 1 whenever a run is active, so E-1 cannot underflow
  assign last_epoch = (epoch_q == (e_q - 1'b1));

endmodule

// File: rtl/lr_train_ctrl.sv
// Start/done sequencer for the SGD datapath: RAM reads, multiplier sharing
// between forward and update passes, and weight-write gating.
module lr_train_ctrl #(
  parameter int DP_BITS    = 4,
  parameter int EPOCH_BITS = 8,
  parameter int RAM_LAT    = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  halt,
  input  logic [DP_BITS-1:0]    num_dps,
  input  logic [EPOCH_BITS-1:0] num_epochs,
  output logic                  ram_en,
  output logic [DP_BITS-1:0]    ram_addr,
  output logic                  a_load,
  output logic                  b_sel,
  output logic                  b_load,
  output logic                  err_load,
  output logic                  wt_we,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [EPOCH_BITS-1:0] epoch
);

  import lr_pkg::*;

  state_t state_q, state_d;
  logic   cfg_err_q, cfg_err_d;
  logic   cnt_load, cnt_step;
  logic   last_dp, last_epoch;

  lr_loop_counter #(
    .DP_BITS    (DP_BITS),
    .EPOCH_BITS (EPOCH_BITS)
  ) u_cnt (
    .clk        (CLK),
    .rst_n      (RST_N),
    .load       (cnt_load),
    .step       (cnt_step),
    .n_in       (num_dps),
    .e_in       (num_epochs),
    .addr       (ram_addr),
    .epoch      (epoch),
    .last_dp    (last_dp),
    .last_epoch (last_epoch)
  );

  always_comb begin
    state_d   = state_q;
    cfg_err_d = 1'b0;
    cnt_load  = 1'b0;
    cnt_step  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_dps == '0 || num_epochs == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            cnt_load = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = (RAM_LAT == 2) ? S_WAIT : S_FWD;
      S_WAIT:  state_d = S_FWD;
      S_FWD:   state_d = S_ERR;
      S_ERR:   state_d = S_UPD;
      S_UPD:   state_d = S_WRT;
      S_WRT: begin
        cnt_step = 1'b1;
        state_d  = (last_dp && last_epoch) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort freezes address/epoch where they stand
    if (halt && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      cnt_step = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    ram_en   = 1'b0;
    a_load   = 1'b0;
    b_sel    = 1'b0;
    b_load   = 1'b0;
    err_load = 1'b0;
    wt_we    = 1'b0;
    done     = 1'b0;
    unique case (1'b1)
      (state_q == S_FETCH),
      (state_q == S_WAIT): ram_en = 1'b1;
      (state_q == S_FWD): begin
        a_load = 1'b1;
        b_load = 1'b1;
      end
      (state_q == S_ERR): begin
        err_load = 1'b1;
        b_sel    = 1'b1;
      end
      (state_q == S_UPD): begin
        b_load = 1'b1;
        b_sel  = 1'b1;
      end
      (state_q == S_WRT): begin
        b_sel = 1'b1;
        wt_we = !halt;
      end
      (state_q == S_DONE): done = 1'b1;
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign cfg_err = cfg_err_q;

endmodule

// File: doc/lr_train_ctrl.md
# lr_train_ctrl

Sequencing controller for the linear-regression SGD datapath: the six `bw_mul` multipliers, weight registers, `y_cap`/`common_p` error logic and the data-point RAM. It replaces the free-running four-state loop with an explicit start/done training run. For each run it walks the data points over a programmable number of epochs, issues RAM reads, and time-shares the multiplier bank between the forward pass (feature × weight) and the update pass (feature × `common_p`). It also gates weight writes.

## Interface
- `DP_BITS`, 4, width of data-point address; MAX_DP = 2**DP_BITS
- `EPOCH_BITS`, 8, width of epoch count
- `RAM_LAT`, 1, RAM2 read latency in cycles (1 or 2)
- `CLK`  in  1  clock, rising edge
- `RST_N`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin run; sampled only in IDLE
- `halt`  in  1  abort run; returns to IDLE next edge
- `num_dps`  in  DP_BITS  number of data points N (1..MAX_DP-1); latched at start
- `num_epochs`  in  EPOCH_BITS  epochs E (≥1); latched at start
- `ram_en`  out  1  RAM2 read enable
- `ram_addr`  out  DP_BITS  data-point address
- `a_load`  out  1  capture RAM features into A_vals
- `b_sel`  out  1  B operand source: 0 = weights, 1 = `common_p`
- `b_load`  out  1  capture B_vals
- `err_load`  out  1  register `y_cap[addr]` and `common_p`
- `wt_we`  out  1  weight update `wt[c] += P[c]`
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at run completion
- `cfg_err`  out  1  one-cycle pulse: start with N=0 or E=0
- `epoch`  out  EPOCH_BITS  completed-epoch count

## Operation
- States, Gray-coded: IDLE, FETCH, WAIT, FWD, ERR, UPD, WRT, DONE.
- IDLE with `start`=1:
  - If N=0 or E=0: pulse `cfg_err`, stay in IDLE.
  - Otherwise latch N and E, set `ram_addr`=N-1, `epoch`=0, go to FETCH.
- FETCH: `ram_en`=1. Next state is WAIT if RAM_LAT=2, else FWD.
- WAIT: `ram_en`=1, then FWD.
- FWD: `a_load`=1, `b_load`=1, `b_sel`=0, then ERR.
- ERR: `err_load`=1, `b_sel`=1, then UPD.
- UPD: `b_load`=1, `b_sel`=1, then WRT.
- WRT: `wt_we`=1, `b_sel`=1.
  - If `ram_addr`≠0: decrement it, go to FETCH.
  - If `ram_addr`=0: increment `epoch` and reload `ram_addr`=N-1.
    - If the new epoch count equals E, go to DONE; else go to FETCH.
- DONE: `done`=1, then IDLE. `epoch` holds E until the next accepted start.
- `busy`=1 in every state except IDLE.
- `start` is ignored while busy. Changes to `num_dps`/`num_epochs` mid-run have no effect.
- `halt`:
  - In any non-IDLE state, the next state is IDLE. No `done` pulse.
  - `wt_we` is combinationally masked by `halt` in WRT (no partial update).
  - `epoch` and `ram_addr` keep their values at the point of abort.
- `halt` and `start` together in IDLE: `start` wins; `halt` is ignored in IDLE.
- Outputs are Moore-decoded from state, except that `wt_we` is gated by `halt`.

## Timing
- Reset (RST_N=0, async): state=IDLE, `ram_addr`=0, `epoch`=0, all strobes 0, `busy`=0.
- Per data point: 5 cycles (RAM_LAT=1) or 6 cycles (RAM_LAT=2).
- Start accepted at edge 0 → `done` is high in cycle (5 or 6)·N·E + 1; `busy` falls the cycle after.
- RAM data is valid in the FWD cycle. `a_load` captures it at the end of FWD.
- Multiplier products are valid one cycle after `b_load`: forward products in ERR, update products in WRT.
- Epoch wrap: `ram_addr` goes 0 → N-1 in the same edge that increments `epoch`.
- E = 2**EPOCH_BITS-1 is legal. `epoch` never wraps inside a run.

## Structure
- Package `lr_pkg`:
  - state typedef with its Gray encodings
  - `DP_BITS`, `EPOCH_BITS`, `MAX_FEATURES`=6, `LR_SHIFT`=7, Q8.8 width 16
- Sub-module `lr_loop_counter`:
  - down-counting address with reload
  - epoch up-counter with terminal flag
  - inputs: load, step; outputs: addr, epoch, last_dp, last_epoch
- The FSM stays in `lr_train_ctrl`. The datapath stays in `LR_alt`-style top, driven by these strobes.

## Test plan
- N=3, E=2, RAM_LAT=1, start at cycle 0 → `ram_addr` sequence 2,1,0,2,1,0; six `wt_we` pulses; `done` at cycle 31; `epoch`=2.
- Same run with RAM_LAT=2 → WAIT visited each point; `done` at cycle 37.
- Start with N=0 (and separately E=0) → `cfg_err` pulse, `busy` stays 0, no `ram_en`.
- `halt` asserted in second WRT of N=4, E=1 → that `wt_we` suppressed, IDLE next cycle, no `done`, `ram_addr`=2.
- `start` pulsed while busy, and N changed mid-run → run unaffected, total `wt_we` count equals original N·E.
- RST_N dropped mid-UPD asynchronously → outputs zero immediately; next start runs cleanly from `epoch`=0.
